// File: rtl/ld_port_arb_pkg.sv
// +--------------------------------------------------------------------------+
// | ld_port_arb_pkg : shared types, state encoding and arbitration helper    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

package ld_port_arb_pkg;

  localparam int MaxLdPorts    = 8;
  localparam int c_max_ports_w = 3;
  localparam int c_index_w     = 12;
  localparam int c_tag_w       = 20;
  localparam int c_data_w      = 64;
  localparam int c_be_w        = c_data_w / 8;

  typedef struct packed {
    logic                 data_req;
    logic [c_index_w-1:0] address_index;
    logic [c_tag_w-1:0]   address_tag;
    logic                 tag_valid;
    logic                 kill_req;
    logic [c_be_w-1:0]    data_be;
    logic [1:0]           data_size;
  } dcache_req_i_t;

  typedef struct packed {
    logic                data_gnt;
    logic                data_rvalid;
    logic [c_data_w-1:0] data_rdata;
  } dcache_req_o_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_GNT = 2'd1,
    SEND_TAG = 2'd2
  } ld_arb_state_e;

  // Returns {found, index}; unused request bits are zero, so wrapping at
  // MaxLdPorts orders the live requesters the same as wrapping at NumPorts.
  function automatic logic [c_max_ports_w:0] rr_pick(input logic [MaxLdPorts-1:0]  req,
                                                     input logic [c_max_ports_w-1:0] ptr);
    logic [c_max_ports_w:0]   res;
    logic [c_max_ports_w-1:0] idx;
    res = '0;
    for (int i = MaxLdPorts - 1; i >= 0; i--) begin
      idx = ptr + c_max_ports_w'(i);
      if (req[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ld_arb_id_fifo.sv
// +--------------------------------------------------------------------------+
// | ld_arb_id_fifo : in-order queue of requester IDs awaiting read data      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module ld_arb_id_fifo #(
  parameter int Depth = 4,
  parameter int Width = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [Width-1:0] data_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [Width-1:0] head_o
);

  localparam int c_ptr_w = $clog2(Depth);

  logic [Width-1:0]   r_mem [Depth];
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_ptr_w:0]   r_count;
  logic               w_do_push;
  logic               w_do_pop;

  assign full_o    = (r_count == (c_ptr_w + 1)'(Depth));
  assign empty_o   = (r_count == '0);
  assign head_o    = r_mem[r_rd_ptr];
  assign w_do_push = push_i && (!full_o || pop_i);
  assign w_do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_do_push) r_mem[r_wr_ptr] <= data_i;
  end

endmodule

`default_nettype wire

// File: rtl/ld_port_arbiter.sv
// +--------------------------------------------------------------------------+
// | ld_port_arbiter : shares one D$ load port among NumPorts requesters and  |
// | steers read data back in order. LD_PORT_ARB_FIXED_PRIO_EN selects fixed  |
// | lowest-index priority instead of round-robin.                            |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module ld_port_arbiter
  import ld_port_arb_pkg::*;
#(
  parameter int NumPorts = 3,
  parameter int IdDepth  = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          flush_i,
  input  dcache_req_i_t req_i [NumPorts],
  output dcache_req_o_t rsp_o [NumPorts],
  output dcache_req_i_t cache_req_o,
  input  dcache_req_o_t cache_rsp_i,
  output logic          busy_o,
  output logic          err_rsp_o
);

  localparam int IdW = $clog2(NumPorts);

  ld_arb_state_e            r_state;
  ld_arb_state_e            w_state_d;
  logic [IdW-1:0]           r_owner;
  logic [IdW-1:0]           w_owner_d;
  logic [MaxLdPorts-1:0]    w_req_vec;
  logic [c_max_ports_w-1:0] w_ptr;
  logic [c_max_ports_w:0]   w_pick;
  logic [IdW-1:0]           w_pick_idx;
  logic                     w_push;
  logic                     w_pop;
  logic                     w_full;
  logic                     w_empty;
  logic [IdW-1:0]           w_head;

  always_comb begin
    w_req_vec = '0;
    for (int p = 0; p < NumPorts; p++) w_req_vec[p] = req_i[p].data_req;
  end

`ifdef LD_PORT_ARB_FIXED_PRIO_EN
  assign w_ptr = '0;
`else
  logic [IdW-1:0] r_rr_ptr;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rr_ptr <= '0;
    end else if (r_state == WAIT_GNT && req_i[r_owner].data_req && cache_rsp_i.data_gnt) begin
      r_rr_ptr <= (r_owner == IdW'(NumPorts - 1)) ? '0 : r_owner + 1'b1;
    end
  end

  assign w_ptr = c_max_ports_w'(r_rr_ptr);
`endif

  assign w_pick     = rr_pick(w_req_vec, w_ptr);
  assign w_pick_idx = IdW'(w_pick[c_max_ports_w-1:0]);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_owner <= '0;
    end else begin
      r_state <= w_state_d;
      r_owner <= w_owner_d;
    end
  end

  always_comb begin
    w_state_d   = r_state;
    w_owner_d   = r_owner;
    w_push      = 1'b0;
    w_pop       = 1'b0;
    cache_req_o = '0;
    err_rsp_o   = 1'b0;
    for (int p = 0; p < NumPorts; p++) begin
      rsp_o[p].data_gnt    = 1'b0;
      rsp_o[p].data_rvalid = 1'b0;
      rsp_o[p].data_rdata  = cache_rsp_i.data_rdata;
    end

    case (r_state)
      IDLE: begin
        if (!flush_i && !w_full && w_pick[c_max_ports_w]) begin
          cache_req_o.data_req      = 1'b1;
          cache_req_o.address_index = req_i[w_pick_idx].address_index;
          cache_req_o.data_be       = req_i[w_pick_idx].data_be;
          cache_req_o.data_size     = req_i[w_pick_idx].data_size;
          w_owner_d                 = w_pick_idx;
          w_state_d                 = WAIT_GNT;
        end
      end
      WAIT_GNT: begin
        cache_req_o.data_req        = req_i[r_owner].data_req;
        cache_req_o.address_index   = req_i[r_owner].address_index;
        cache_req_o.data_be         = req_i[r_owner].data_be;
        cache_req_o.data_size       = req_i[r_owner].data_size;
        rsp_o[r_owner].data_gnt     = cache_rsp_i.data_gnt;
        if (!req_i[r_owner].data_req) begin
          w_state_d = IDLE;
        end else if (cache_rsp_i.data_gnt) begin
          w_state_d = SEND_TAG;
        end
      end
      SEND_TAG: begin
        cache_req_o.address_tag = req_i[r_owner].address_tag;
        cache_req_o.tag_valid   = req_i[r_owner].tag_valid;
        cache_req_o.kill_req    = req_i[r_owner].kill_req | flush_i;
        w_push    = req_i[r_owner].tag_valid && !cache_req_o.kill_req;
        w_state_d = IDLE;
      end
      default: w_state_d = IDLE;
    endcase

    // Read data returns in request order, so the queue head owns it.
    if (cache_rsp_i.data_rvalid) begin
      if (!w_empty) begin
        rsp_o[w_head].data_rvalid = 1'b1;
        w_pop                     = 1'b1;
      end else begin
        err_rsp_o = 1'b1;
      end
    end

    busy_o = (r_state != IDLE) || !w_empty;

    if (rst_i) begin
      cache_req_o = '0;
      err_rsp_o   = 1'b0;
      busy_o      = 1'b0;
      for (int p = 0; p < NumPorts; p++) rsp_o[p] = '0;
    end
  end

  ld_arb_id_fifo #(
    .Depth (IdDepth),
    .Width (IdW)
  ) u_id_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (w_push),
    .pop_i   (w_pop),
    .data_i  (r_owner),
    .full_o  (w_full),
    .empty_o (w_empty),
    .head_o  (w_head)
  );

endmodule

`default_nettype wire

// File: tb/tb_ld_port_arbiter.sv
// +--------------------------------------------------------------------------+
// | tb_ld_port_arbiter : directed scoreboard bench for ld_port_arbiter       |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_ld_port_arbiter;
  import ld_port_arb_pkg::*;

  localparam int NP = 3;

  typedef struct {
    int          port;
    logic [63:0] data;
  } rv_t;

  logic          clk;
  logic          rst;
  logic          flush;
  dcache_req_i_t req [NP];
  dcache_req_o_t rsp [NP];
  dcache_req_i_t cache_req;
  dcache_req_o_t cache_rsp;
  logic          busy;
  logic          err;

  int  vectors;
  int  miscompares;
  int  exp_gnt[$];
  rv_t exp_rv[$];
  int  exp_err[$];
  int  mon_e;
  rv_t mon_r;

  ld_port_arbiter #(.NumPorts(NP), .IdDepth(4)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .flush_i     (flush),
    .req_i       (req),
    .rsp_o       (rsp),
    .cache_req_o (cache_req),
    .cache_rsp_i (cache_rsp),
    .busy_o      (busy),
    .err_rsp_o   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: every DUT-presented gnt / rvalid / err pops an expectation.
  always @(negedge clk) begin
    if (!rst) begin
      for (int p = 0; p < NP; p++) begin
        if (rsp[p].data_gnt) begin
          vectors++;
          if (exp_gnt.size() == 0) begin
            miscompares++;
            $display("FAIL gnt_unexpected: port %0d got gnt, expected none", p);
          end else begin
            mon_e = exp_gnt.pop_front();
            if (mon_e != p) begin
              miscompares++;
              $display("FAIL gnt_port: got port %0d, expected port %0d", p, mon_e);
            end
          end
        end
        if (rsp[p].data_rvalid) begin
          vectors++;
          if (exp_rv.size() == 0) begin
            miscompares++;
            $display("FAIL rvalid_unexpected: port %0d got rvalid, expected none", p);
          end else begin
            mon_r = exp_rv.pop_front();
            if (mon_r.port != p || rsp[p].data_rdata !== mon_r.data) begin
              miscompares++;
              $display("FAIL rvalid: got port %0d data %0h, expected port %0d data %0h",
                       p, rsp[p].data_rdata, mon_r.port, mon_r.data);
            end
          end
        end
      end
      if (err) begin
        vectors++;
        if (exp_err.size() == 0) begin
          miscompares++;
          $display("FAIL err_unexpected: got err_rsp 1, expected 0");
        end else begin
          mon_e = exp_err.pop_front();
        end
      end
    end
  end

  // One full tagged/untagged transaction from IDLE back to IDLE.
  task automatic do_txn(input int p, input logic [11:0] idx, input logic [19:0] tag, input logic tv);
    req[p].data_req      = 1'b1;
    req[p].address_index = idx;
    req[p].data_be       = 8'hFF;
    req[p].data_size     = 2'd3;
    #1;
    chk("txn_req", 64'(cache_req.data_req), 64'd1);
    chk("txn_idx", 64'(cache_req.address_index), 64'(idx));
    exp_gnt.push_back(p);
    tick();
    cache_rsp.data_gnt = 1'b1;
    tick();
    cache_rsp.data_gnt   = 1'b0;
    req[p].data_req      = 1'b0;
    req[p].address_tag   = tag;
    req[p].tag_valid     = tv;
    #1;
    chk("txn_tag", 64'(cache_req.address_tag), 64'(tag));
    chk("txn_tag_valid", 64'(cache_req.tag_valid), 64'(tv));
    tick();
    req[p].tag_valid = 1'b0;
  endtask

  task automatic give_rv(input int p, input logic [63:0] d);
    cache_rsp.data_rvalid = 1'b1;
    cache_rsp.data_rdata  = d;
    exp_rv.push_back('{port: p, data: d});
    tick();
    cache_rsp.data_rvalid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    flush       = 1'b0;
    cache_rsp   = '0;
    for (int p = 0; p < NP; p++) req[p] = '0;
    req[0].data_req = 1'b1;
    cache_rsp.data_rdata = 64'h1234;
    tick();
    tick();
    // Outputs are forced to zero while reset is held even with live inputs.
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_cache_req", 64'(cache_req), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_rdata0", rsp[0].data_rdata, 64'd0);
    req[0].data_req = 1'b0;
    cache_rsp.data_rdata = '0;
    rst = 1'b0;
    tick();

    // Round-robin: three continuous requesters, gnt held high.
`ifdef LD_PORT_ARB_FIXED_PRIO_EN
    exp_gnt.push_back(0); exp_gnt.push_back(0); exp_gnt.push_back(0); exp_gnt.push_back(0);
`else
    exp_gnt.push_back(0); exp_gnt.push_back(1); exp_gnt.push_back(2); exp_gnt.push_back(0);
`endif
    for (int p = 0; p < NP; p++) req[p].data_req = 1'b1;
    cache_rsp.data_gnt = 1'b1;
    repeat (12) tick();
    for (int p = 0; p < NP; p++) req[p].data_req = 1'b0;
    cache_rsp.data_gnt = 1'b0;
    #1;
    chk("rr_all_granted", 64'(exp_gnt.size()), 64'd0);
    chk("rr_busy_idle", 64'(busy), 64'd0);
    tick();

    // Single tagged request on port 1, gnt in the second WAIT_GNT cycle.
    req[1].data_req      = 1'b1;
    req[1].address_index = 12'h123;
    req[1].data_be       = 8'hFF;
    req[1].data_size     = 2'd3;
    #1;
    chk("single_req_same_cycle", 64'(cache_req.data_req), 64'd1);
    exp_gnt.push_back(1);
    tick();
    chk("single_wait_idx", 64'(cache_req.address_index), 64'h123);
    chk("single_busy", 64'(busy), 64'd1);
    tick();
    cache_rsp.data_gnt = 1'b1;
    tick();
    cache_rsp.data_gnt  = 1'b0;
    req[1].data_req     = 1'b0;
    req[1].address_tag  = 20'hABCDE;
    req[1].tag_valid    = 1'b1;
    #1;
    chk("single_tag", 64'(cache_req.address_tag), 64'hABCDE);
    chk("single_tag_valid", 64'(cache_req.tag_valid), 64'd1);
    chk("single_kill", 64'(cache_req.kill_req), 64'd0);
    tick();
    req[1].tag_valid = 1'b0;
    #1;
    chk("single_busy_queued", 64'(busy), 64'd1);
    repeat (3) tick();
    give_rv(1, 64'hDEAD_BEEF_0000_0001);
    chk("single_busy_done", 64'(busy), 64'd0);

    // Fill the ID queue, then a fifth request must be held off.
    do_txn(0, 12'h010, 20'h00010, 1'b1);
    do_txn(1, 12'h011, 20'h00011, 1'b1);
    do_txn(2, 12'h012, 20'h00012, 1'b1);
    do_txn(0, 12'h013, 20'h00013, 1'b1);
    req[1].data_req      = 1'b1;
    req[1].address_index = 12'h055;
    cache_rsp.data_gnt   = 1'b1;
    #1;
    chk("full_block", 64'(cache_req.data_req), 64'd0);
    tick();
    chk("full_block2", 64'(cache_req.data_req), 64'd0);
    cache_rsp.data_gnt    = 1'b0;
    cache_rsp.data_rvalid = 1'b1;
    cache_rsp.data_rdata  = 64'hA0;
    exp_rv.push_back('{port: 0, data: 64'hA0});
    #1;
    chk("full_pop_same_cycle_block", 64'(cache_req.data_req), 64'd0);
    exp_gnt.push_back(1);
    tick();
    cache_rsp.data_rvalid = 1'b0;
    #1;
    chk("full_release_req", 64'(cache_req.data_req), 64'd1);
    tick();
    cache_rsp.data_gnt = 1'b1;
    tick();
    cache_rsp.data_gnt = 1'b0;
    req[1].data_req    = 1'b0;
    tick();
    give_rv(1, 64'hA1);
    give_rv(2, 64'hA2);
    give_rv(0, 64'hA3);
    chk("full_drained_busy", 64'(busy), 64'd0);

    // Flush during WAIT_GNT: index completes, tag killed, arbitration held.
    do_txn(1, 12'h020, 20'h00020, 1'b1);
    req[2].data_req      = 1'b1;
    req[2].address_index = 12'h077;
    #1;
    exp_gnt.push_back(2);
    tick();
    flush              = 1'b1;
    cache_rsp.data_gnt = 1'b1;
    #1;
    chk("flush_idx_keep", 64'(cache_req.data_req), 64'd1);
    tick();
    cache_rsp.data_gnt = 1'b0;
    req[2].data_req    = 1'b0;
    req[2].address_tag = 20'h77777;
    req[2].tag_valid   = 1'b1;
    req[0].data_req    = 1'b1;
    #1;
    chk("flush_kill", 64'(cache_req.kill_req), 64'd1);
    tick();
    req[2].tag_valid = 1'b0;
    #1;
    chk("flush_no_arb", 64'(cache_req.data_req), 64'd0);
    tick();
    cache_rsp.data_rvalid = 1'b1;
    cache_rsp.data_rdata  = 64'hF1;
    exp_rv.push_back('{port: 1, data: 64'hF1});
    #1;
    chk("flush_no_arb2", 64'(cache_req.data_req), 64'd0);
    tick();
    cache_rsp.data_rvalid = 1'b0;
    flush                 = 1'b0;
    #1;
    chk("flush_release_req", 64'(cache_req.data_req), 64'd1);
    chk("flush_no_push", 64'(busy), 64'd0);
    exp_gnt.push_back(0);
    tick();
    cache_rsp.data_gnt = 1'b1;
    tick();
    cache_rsp.data_gnt = 1'b0;
    req[0].data_req    = 1'b0;
    tick();

    // Spurious response with an empty queue.
    cache_rsp.data_rvalid = 1'b1;
    cache_rsp.data_rdata  = 64'hBAD;
    exp_err.push_back(1);
    #1;
    chk("spur_err", 64'(err), 64'd1);
    for (int p = 0; p < NP; p++) chk("spur_no_rvalid", 64'(rsp[p].data_rvalid), 64'd0);
    tick();
    cache_rsp.data_rvalid = 1'b0;
    #1;
    chk("spur_err_pulse", 64'(err), 64'd0);

    // Reset in SEND_TAG with two IDs queued.
    do_txn(0, 12'h030, 20'h00030, 1'b1);
    do_txn(1, 12'h031, 20'h00031, 1'b1);
    req[2].data_req      = 1'b1;
    req[2].address_index = 12'h032;
    #1;
    exp_gnt.push_back(2);
    tick();
    cache_rsp.data_gnt = 1'b1;
    tick();
    cache_rsp.data_gnt = 1'b0;
    req[2].address_tag = 20'h00032;
    req[2].tag_valid   = 1'b1;
    rst                = 1'b1;
    #1;
    chk("rst_mid_cache_req", 64'(cache_req), 64'd0);
    chk("rst_mid_busy", 64'(busy), 64'd0);
    chk("rst_mid_err", 64'(err), 64'd0);
    for (int p = 0; p < NP; p++) begin
      chk("rst_mid_gnt", 64'(rsp[p].data_gnt), 64'd0);
      chk("rst_mid_rvalid", 64'(rsp[p].data_rvalid), 64'd0);
      chk("rst_mid_rdata", rsp[p].data_rdata, 64'd0);
    end
    req[2].data_req  = 1'b0;
    req[2].tag_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rst_rel_busy", 64'(busy), 64'd0);
    chk("rst_rel_cache_req", 64'(cache_req), 64'd0);
    cache_rsp.data_rvalid = 1'b1;
    cache_rsp.data_rdata  = 64'hC0;
    exp_err.push_back(1);
    #1;
    chk("rst_queue_cleared", 64'(err), 64'd1);
    tick();
    cache_rsp.data_rvalid = 1'b0;
    tick();

    chk("end_gnt_queue", 64'(exp_gnt.size()), 64'd0);
    chk("end_rv_queue", 64'(exp_rv.size()), 64'd0);
    chk("end_err_queue", 64'(exp_err.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
